// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
//   INITIAL_ADDRESS / HANDLER_ADDRESS : reset PC and exception handler entry
//   IM_BASE / IM_END                  : legal instruction memory window
//   EXC_ADEL                          : address-error-on-load exception code
//   fetch_state_t                     : fetch controller states
package fetch_unit_pkg;

    localparam logic [31:0] INITIAL_ADDRESS = 32'h0000_3000;
    localparam logic [31:0] HANDLER_ADDRESS = 32'h0000_4180;
    localparam logic [31:0] IM_BASE         = 32'h0000_3000;
    localparam logic [31:0] IM_END          = 32'h0000_6FFF;
    localparam logic [4:0]  EXC_ADEL        = 5'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Misaligned or outside the instruction memory window.
    function automatic logic pc_bad(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_END);
    endfunction

endpackage

// File: rtl/fetch_npc.sv
// Next-PC selection for the fetch stage (purely combinational).
//   pc, pend, pend_target     : current PC and delayed-jump bookkeeping
//   d_jump, d_jump_target     : jump resolved in decode this cycle
//   req, eret, epc            : exception flush / exception return
//   adv_pc                    : PC to use when the stage advances
//   redirect, redir_pc        : flush/return taken this cycle and its target
module fetch_npc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        pend,
    input  logic [31:0] pend_target,
    input  logic        d_jump,
    input  logic [31:0] d_jump_target,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] adv_pc,
    output logic        redirect,
    output logic [31:0] redir_pc
);

    always_comb begin
        if (pend)
            adv_pc = pend_target;
        else if (d_jump)
            adv_pc = d_jump_target;
        else
            adv_pc = pc + 32'd4;   // wraps; a wrapped PC is caught as bad

        redirect = req | eret;
        redir_pc = req ? HANDLER_ADDRESS : epc;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with a req/ack instruction bus.
//   clk, reset               : clock, synchronous active-high reset
//   F_en                     : F/D register advance enable from hazard unit
//   D_Jump, D_JumpTarget     : jump resolved in D (applies after delay slot)
//   Req, D_Eret, EPC         : exception flush / exception return redirect
//   i_inst_*                 : instruction bus (req held until ack)
//   F_instr, F_PC, F_ExcCode : fetched instruction, its PC, exception code
//   F_Busy                   : a bubble is being presented
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        F_en,
    input  logic        D_Jump,
    input  logic [31:0] D_JumpTarget,
    input  logic        Req,
    input  logic        D_Eret,
    input  logic [31:0] EPC,
    output logic        i_inst_req,
    output logic [31:0] i_inst_addr,
    input  logic        i_inst_ack,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] F_instr,
    output logic [31:0] F_PC,
    output logic [4:0]  F_ExcCode,
    output logic        F_Busy
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  buf_q;
    logic         pend_q;
    logic [31:0]  pend_tgt_q;
    logic [31:0]  req_addr_q;

    logic         bad;
    logic         issuing;
    logic         delivering;
    logic [31:0]  adv_pc;
    logic         redirect;
    logic [31:0]  redir_pc;

    fetch_npc u_npc (
        .pc            (pc_q),
        .pend          (pend_q),
        .pend_target   (pend_tgt_q),
        .d_jump        (D_Jump),
        .d_jump_target (D_JumpTarget),
        .req           (Req),
        .eret          (D_Eret),
        .epc           (EPC),
        .adv_pc        (adv_pc),
        .redirect      (redirect),
        .redir_pc      (redir_pc)
    );

    always_comb begin
        bad        = pc_bad(pc_q);
        issuing    = (state_q == FETCH) && !bad;
        delivering = ((state_q == FETCH) && (bad || i_inst_ack)) || (state_q == HOLD);
    end

    always_comb begin
        i_inst_req  = 1'b0;
        i_inst_addr = pc_q;
        F_instr     = '0;
        F_PC        = pc_q;
        F_ExcCode   = '0;
        F_Busy      = 1'b0;
        if (reset) begin
            i_inst_addr = INITIAL_ADDRESS;
            F_PC        = INITIAL_ADDRESS;
        end else begin
            case (state_q)
                FETCH: begin
                    if (bad) begin
                        F_ExcCode = EXC_ADEL;
                    end else begin
                        i_inst_req = 1'b1;
                        if (i_inst_ack)
                            F_instr = i_inst_rdata;
                        else
                            F_Busy = 1'b1;
                    end
                end
                HOLD: F_instr = buf_q;
                default: begin
                    i_inst_req  = 1'b1;
                    i_inst_addr = req_addr_q;
                    F_Busy      = 1'b1;
                end
            endcase
            // The instruction in flight when a redirect hits is squashed.
            if (redirect) begin
                F_instr   = '0;
                F_ExcCode = '0;
                F_Busy    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= INITIAL_ADDRESS;
            buf_q      <= '0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            req_addr_q <= INITIAL_ADDRESS;
        end else begin
            if (state_q == FETCH)
                req_addr_q <= pc_q;

            if (redirect) begin
                pc_q   <= redir_pc;
                pend_q <= 1'b0;
                case (state_q)
                    FETCH:   state_q <= (issuing && !i_inst_ack) ? DRAIN : FETCH;
                    HOLD:    state_q <= FETCH;
                    // A redirect in DRAIN only moves PC; the old ack still ends DRAIN.
                    default: state_q <= i_inst_ack ? FETCH : DRAIN;
                endcase
            end else begin
                if (delivering && F_en) begin
                    pc_q    <= adv_pc;
                    pend_q  <= 1'b0;
                    state_q <= FETCH;
                end else if (!delivering && F_en && D_Jump) begin
                    pend_q     <= 1'b1;
                    pend_tgt_q <= D_JumpTarget;
                end

                if (state_q == FETCH && issuing && i_inst_ack && !F_en) begin
                    buf_q   <= i_inst_rdata;
                    state_q <= HOLD;
                end

                if (state_q == DRAIN && i_inst_ack)
                    state_q <= FETCH;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        F_en;
    logic        D_Jump;
    logic [31:0] D_JumpTarget;
    logic        Req;
    logic        D_Eret;
    logic [31:0] EPC;
    logic        i_inst_req;
    logic [31:0] i_inst_addr;
    logic        i_inst_ack;
    logic [31:0] i_inst_rdata;
    logic [31:0] F_instr;
    logic [31:0] F_PC;
    logic [4:0]  F_ExcCode;
    logic        F_Busy;

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .F_en         (F_en),
        .D_Jump       (D_Jump),
        .D_JumpTarget (D_JumpTarget),
        .Req          (Req),
        .D_Eret       (D_Eret),
        .EPC          (EPC),
        .i_inst_req   (i_inst_req),
        .i_inst_addr  (i_inst_addr),
        .i_inst_ack   (i_inst_ack),
        .i_inst_rdata (i_inst_rdata),
        .F_instr      (F_instr),
        .F_PC         (F_PC),
        .F_ExcCode    (F_ExcCode),
        .F_Busy       (F_Busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
    } deliv_t;

    deliv_t sb[$];
    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    task automatic chk(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s.%s: got %h expected %h", tag, what, obs, exp);
        end
    endtask

    task automatic exp_good(input logic [31:0] pc);
        deliv_t d;
        d.pc = pc; d.instr = mem_word(pc); d.exc = 5'd0;
        sb.push_back(d);
    endtask

    task automatic exp_bad(input logic [31:0] pc);
        deliv_t d;
        d.pc = pc; d.instr = 32'd0; d.exc = 5'd4;
        sb.push_back(d);
    endtask

    // One clock: drive en/ack, answer the bus, check at negedge.
    task automatic tick(input string tag, input logic en, input logic ack,
                        input logic exp_req, input logic [31:0] exp_addr,
                        input logic exp_busy);
        deliv_t d;
        F_en = en;
        i_inst_ack = ack;
        #1;
        i_inst_rdata = ack ? mem_word(i_inst_addr) : 32'hDEAD_BEEF;
        @(negedge clk);
        chk(tag, "req", {31'd0, i_inst_req}, {31'd0, exp_req});
        if (exp_req)
            chk(tag, "addr", i_inst_addr, exp_addr);
        chk(tag, "busy", {31'd0, F_Busy}, {31'd0, exp_busy});
        if (exp_busy) begin
            chk(tag, "nop", F_instr, 32'd0);
        end else if (!(Req || D_Eret)) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL %s.sb: got delivery pc %h expected none", tag, F_PC);
            end else begin
                d = en ? sb.pop_front() : sb[0];
                chk(tag, "pc", F_PC, d.pc);
                chk(tag, "instr", F_instr, d.instr);
                chk(tag, "exc", {27'd0, F_ExcCode}, {27'd0, d.exc});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        F_en = 1'b1; D_Jump = 1'b0; D_JumpTarget = '0;
        Req = 1'b0; D_Eret = 1'b0; EPC = '0;
        i_inst_ack = 1'b0; i_inst_rdata = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset", "req", {31'd0, i_inst_req}, 32'd0);
        chk("reset", "pc", F_PC, 32'h3000);
        chk("reset", "instr", F_instr, 32'd0);
        chk("reset", "exc", {27'd0, F_ExcCode}, 32'd0);
        chk("reset", "busy", {31'd0, F_Busy}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // zero-wait streaming
        do_reset();
        exp_good(32'h3000); tick("zw0", 1, 1, 1, 32'h3000, 0);
        exp_good(32'h3004); tick("zw1", 1, 1, 1, 32'h3004, 0);
        exp_good(32'h3008); tick("zw2", 1, 1, 1, 32'h3008, 0);

        // two-cycle ack delay at 0x3004
        do_reset();
        exp_good(32'h3000); tick("dl0", 1, 1, 1, 32'h3000, 0);
        tick("dl1", 1, 0, 1, 32'h3004, 1);
        tick("dl2", 1, 0, 1, 32'h3004, 1);
        exp_good(32'h3004); tick("dl3", 1, 1, 1, 32'h3004, 0);
        exp_good(32'h3008); tick("dl4", 1, 1, 1, 32'h3008, 0);

        // jump resolved while the delay slot is still being fetched
        do_reset();
        exp_good(32'h3000); tick("jp0", 1, 1, 1, 32'h3000, 0);
        exp_good(32'h3004); tick("jp1", 1, 1, 1, 32'h3004, 0);
        D_Jump = 1; D_JumpTarget = 32'h3100;
        tick("jp2", 1, 0, 1, 32'h3008, 1);
        D_Jump = 0;
        exp_good(32'h3008); tick("jp3", 1, 1, 1, 32'h3008, 0);
        exp_good(32'h3100); tick("jp4", 1, 1, 1, 32'h3100, 0);
        D_Jump = 1; D_JumpTarget = 32'h3200;
        exp_good(32'h3104); tick("jp5", 1, 1, 1, 32'h3104, 0);
        D_Jump = 0;
        exp_good(32'h3200); tick("jp6", 1, 1, 1, 32'h3200, 0);

        // flush with a request outstanding -> drain
        do_reset();
        exp_good(32'h3000); tick("fl0", 1, 1, 1, 32'h3000, 0);
        exp_good(32'h3004); tick("fl1", 1, 1, 1, 32'h3004, 0);
        exp_good(32'h3008); tick("fl2", 1, 1, 1, 32'h3008, 0);
        exp_good(32'h300C); tick("fl3", 1, 1, 1, 32'h300C, 0);
        tick("fl4", 1, 0, 1, 32'h3010, 1);
        Req = 1;
        tick("fl5", 1, 0, 1, 32'h3010, 1);
        Req = 0;
        tick("fl6", 1, 0, 1, 32'h3010, 1);
        tick("fl7", 1, 1, 1, 32'h3010, 1);
        exp_good(32'h4180); tick("fl8", 1, 1, 1, 32'h4180, 0);
        D_Eret = 1; EPC = 32'h3040;
        tick("er0", 1, 1, 1, 32'h4184, 1);
        D_Eret = 0;
        exp_good(32'h3040); tick("er1", 1, 1, 1, 32'h3040, 0);
        Req = 1; D_Eret = 1; EPC = 32'h3080;
        tick("pr0", 1, 1, 1, 32'h3044, 1);
        Req = 0; D_Eret = 0;
        exp_good(32'h4180); tick("pr1", 1, 1, 1, 32'h4180, 0);
        tick("dr0", 1, 0, 1, 32'h4184, 1);
        Req = 1;
        tick("dr1", 1, 0, 1, 32'h4184, 1);
        Req = 0; D_Eret = 1; EPC = 32'h3080;
        tick("dr2", 1, 0, 1, 32'h4184, 1);
        D_Eret = 0;
        tick("dr3", 1, 1, 1, 32'h4184, 1);
        exp_good(32'h3080); tick("dr4", 1, 1, 1, 32'h3080, 0);

        // bad PCs: misaligned, end of window, wrap
        do_reset();
        D_Jump = 1; D_JumpTarget = 32'h3002;
        exp_good(32'h3000); tick("bd0", 1, 1, 1, 32'h3000, 0);
        D_Jump = 0;
        exp_bad(32'h3002); tick("bd1", 1, 0, 0, 32'h0, 0);
        Req = 1;
        tick("bd2", 1, 0, 0, 32'h0, 1);
        Req = 0; D_Jump = 1; D_JumpTarget = 32'h6FFC;
        exp_good(32'h4180); tick("bd3", 1, 1, 1, 32'h4180, 0);
        D_Jump = 0;
        exp_good(32'h6FFC); tick("bd4", 1, 1, 1, 32'h6FFC, 0);
        D_Jump = 1; D_JumpTarget = 32'hFFFF_FFFC;
        exp_bad(32'h7000); tick("bd5", 1, 0, 0, 32'h0, 0);
        D_Jump = 0;
        exp_bad(32'hFFFF_FFFC); tick("bd6", 1, 0, 0, 32'h0, 0);
        exp_bad(32'h0000_0000); tick("bd7", 1, 0, 0, 32'h0, 0);

        // stall at ack -> hold buffered instruction
        do_reset();
        exp_good(32'h3000); tick("hd0", 1, 1, 1, 32'h3000, 0);
        exp_good(32'h3004); tick("hd1", 0, 1, 1, 32'h3004, 0);
        tick("hd2", 0, 0, 0, 32'h0, 0);
        tick("hd3", 0, 0, 0, 32'h0, 0);
        tick("hd4", 0, 0, 0, 32'h0, 0);
        tick("hd5", 1, 0, 0, 32'h0, 0);
        exp_good(32'h3008); tick("hd6", 1, 1, 1, 32'h3008, 0);

        chk("end", "sb_left", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have: reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: F_en  in  1  hazard-unit advance enable; the F/D register latches this block's outputs when high.
REQ-004 SHALL have: D_Jump  in  1 / D_JumpTarget  in  32  branch/jump resolved in D; the target applies after the delay slot.
REQ-005 SHALL have: Req  in  1  CP0 exception/interrupt flush; D_Eret  in  1 / EPC  in  32  return redirect.
REQ-006 SHALL have: i_inst_req  out  1 / i_inst_addr  out  32 / i_inst_ack  in  1 / i_inst_rdata  in  32  instruction bus.
REQ-007 SHALL have: F_instr  out  32 / F_PC  out  32 / F_ExcCode  out  5 / F_Busy  out  1  (busy means a bubble is presented).

Function
REQ-008 SHALL hold PC, state {FETCH, HOLD, DRAIN}, instr buffer, pending-jump flag and target, and latched request address.
REQ-009 SHALL flag PC as bad when PC[1:0]!=0 or PC is outside 0x3000..0x6FFF; a bad PC issues no bus request.
REQ-010 Bus rule: once i_inst_req is high, i_inst_addr SHALL stay stable and i_inst_req SHALL stay high until the cycle i_inst_ack=1.
REQ-011 FETCH, good PC: SHALL drive i_inst_req=1, i_inst_addr=PC; without ack SHALL output F_instr=0, F_PC=PC, F_ExcCode=0, F_Busy=1.
REQ-012 FETCH, ack: SHALL pass i_inst_rdata through, F_PC=PC, ExcCode 0, Busy 0; F_en=1 advances PC and stays in FETCH; F_en=0 buffers the data and goes to HOLD.
REQ-013 FETCH, bad PC: SHALL output F_instr=0, F_PC=PC, F_ExcCode=4 (AdEL), F_Busy=0; F_en=1 advances PC.
REQ-014 HOLD: SHALL present the buffer, F_PC=PC, Busy 0, no request; F_en=1 advances PC and goes to FETCH.
REQ-015 "Delivering" SHALL mean: FETCH with ack, FETCH with bad PC, or HOLD.
REQ-016 Advance SHALL set next PC by priority: pending target (clear the flag), then D_JumpTarget if D_Jump=1, then PC+4.
REQ-017 D_Jump=1 with F_en=1 while not delivering SHALL set pending flag and target; PC SHALL stay unchanged.
REQ-018 Req=1 (any state, regardless of F_en) SHALL set PC=0x4180 and clear pending; D_Eret=1 SHALL do the same to EPC; Req SHALL take priority over D_Eret.
REQ-019 On a redirect while a request is outstanding without ack, the block SHALL go to DRAIN; otherwise it SHALL go to FETCH; the current instruction SHALL never be delivered (output nop, Busy 1 in that cycle).
REQ-020 DRAIN: SHALL keep i_inst_req=1 with the latched old address, output a nop with Busy 1, discard data on ack, then go to FETCH at the new PC.
REQ-021 A redirect arriving during DRAIN SHALL update PC only and stay in DRAIN.
REQ-022 PC+4 arithmetic SHALL be 32-bit and SHALL wrap; a wrapped PC is caught as bad by REQ-009.

Reset
REQ-023 When reset=1 at a clock edge: PC=0x3000, state FETCH, pending=0, buffer=0.
REQ-024 During the reset cycle, i_inst_req SHALL be 0 and outputs SHALL be F_instr=0, F_PC=0x3000, F_ExcCode=0, F_Busy=0.
REQ-025 Reset SHALL override all inputs, including an outstanding request; the bus is presumed reset with it.

Structure
REQ-026 The shared constants file SHALL hold INITIAL_ADDRESS 0x3000, HANDLER_ADDRESS 0x4180, IM_BASE 0x3000, IM_END 0x6FFF, EXC_ADEL 5'd4, and the state encodings.
REQ-027 Next-PC priority selection SHALL live in one combinational sub-module, fetch_npc; everything else stays in fetch_unit.

Verification
REQ-028 Zero-wait bus (ack tied 1), F_en=1, after reset -> F_PC sequence 0x3000, 0x3004, 0x3008, Busy always 0.
REQ-029 Ack delayed 2 cycles at 0x3004 -> two nop/Busy cycles, i_inst_addr held at 0x3004, then the instruction is delivered.
REQ-030 D_Jump=1, target 0x3100, during delay-slot wait -> pending set; delay slot 0x3008 is delivered, then 0x3100.
REQ-031 Req=1 with request outstanding at 0x3010 -> DRAIN; the stale ack is discarded; next request is at 0x4180 and delivered with F_PC=0x4180.
REQ-032 D_Jump target 0x3002 -> F_PC=0x3002, F_instr=0, F_ExcCode=4, no i_inst_req.
REQ-033 F_en=0 at ack -> HOLD; the instruction stays stable for 3 cycles, no new request; F_en=1 -> PC+4.
